// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU data-RAM to SRAM bridge.
// Holds the bridge FSM encoding and bus width constants.
package mem_bus_pkg;

  localparam int REG_DATA_BUS  = 32;
  localparam int SRAM_WAIT_MAX = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD,
    S_DONE
  } sram_state_t;

endpackage

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns single-word CPU data-RAM requests into
// timed cycles on an asynchronous 32-bit SRAM.
// CPU side : CLK, RST (sync, active-low), RAM_CEN/WEN/LSADDR/SDATA/
//            BYTE_SEL in; RAM_LDATA and RAM_READY (1-cycle pulse) out.
// SRAM side: SRAM_ADDR, SRAM_DQ_O/OE, SRAM_CE_N/OE_N/WE_N/BE_N out;
//            SRAM_DQ_I in. Every output is a flop.
module data_sram_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RAM_CEN,
  input  logic                    RAM_WEN,
  input  logic [REG_DATA_BUS-1:0] RAM_LSADDR,
  input  logic [REG_DATA_BUS-1:0] RAM_SDATA,
  input  logic [3:0]              RAM_BYTE_SEL,
  output logic [REG_DATA_BUS-1:0] RAM_LDATA,
  output logic                    RAM_READY,
  output logic [ADDR_W-1:0]       SRAM_ADDR,
  input  logic [REG_DATA_BUS-1:0] SRAM_DQ_I,
  output logic [REG_DATA_BUS-1:0] SRAM_DQ_O,
  output logic                    SRAM_DQ_OE,
  output logic                    SRAM_CE_N,
  output logic                    SRAM_OE_N,
  output logic                    SRAM_WE_N,
  output logic [3:0]              SRAM_BE_N
);

  localparam int WAIT_EFF =
    (WAIT_CYCLES > SRAM_WAIT_MAX) ? SRAM_WAIT_MAX :
    (WAIT_CYCLES < 1)             ? 1 : WAIT_CYCLES;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_EFF - 1);

  sram_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic        accept;
  logic        capture;
  logic        busy_d;
  logic        wr_d;

  // Byte offset and high address bits wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits =
    ^{RAM_LSADDR[REG_DATA_BUS-1:ADDR_W+2], RAM_LSADDR[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RAM_CEN) begin
          accept = 1'b1;
          if (!RAM_WEN) begin
            state_d = S_READ;
            cnt_d   = WAIT_LD;
          end else if (RAM_BYTE_SEL != 4'h0) begin
            state_d = S_WSETUP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSETUP: begin
        state_d = S_WPULSE;
        cnt_d   = WAIT_LD;
      end
      S_WPULSE: begin
        if (cnt_q == 4'd0) state_d = S_WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WHOLD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so that the
  // registered pins line up with the state they belong to.
  always_comb begin
    sel_d  = accept ? RAM_BYTE_SEL : sel_q;
    wr_d   = (state_d == S_WSETUP) || (state_d == S_WPULSE) ||
             (state_d == S_WHOLD);
    busy_d = wr_d || (state_d == S_READ);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= 4'h0;
      RAM_READY  <= 1'b0;
      RAM_LDATA  <= '0;
      SRAM_ADDR  <= '0;
      SRAM_DQ_O  <= '0;
      SRAM_DQ_OE <= 1'b0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_BE_N  <= 4'hF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      RAM_READY  <= (state_d == S_DONE);
      SRAM_DQ_OE <= wr_d;
      SRAM_CE_N  <= !busy_d;
      SRAM_OE_N  <= (state_d != S_READ);
      SRAM_WE_N  <= (state_d != S_WPULSE);
      SRAM_BE_N  <= busy_d ? ~sel_d : 4'hF;
      if (accept) begin
        SRAM_ADDR <= RAM_LSADDR[ADDR_W+1:2];
        SRAM_DQ_O <= RAM_SDATA;
      end
      if (capture) RAM_LDATA <= SRAM_DQ_I;
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge with a small SRAM model.
// Vector table for single ops plus hand sequences for corner cases.
module tb_data_sram_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RAM_CEN;
  logic        RAM_WEN;
  logic [31:0] RAM_LSADDR;
  logic [31:0] RAM_SDATA;
  logic [3:0]  RAM_BYTE_SEL;
  logic [31:0] RAM_LDATA;
  logic        RAM_READY;
  logic [19:0] SRAM_ADDR;
  logic [31:0] SRAM_DQ_I;
  logic [31:0] SRAM_DQ_O;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [3:0]  SRAM_BE_N;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  logic preload;

  logic [31:0] mem [256];

  always #5 CLK = ~CLK;

  data_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST),
    .RAM_CEN(RAM_CEN), .RAM_WEN(RAM_WEN),
    .RAM_LSADDR(RAM_LSADDR), .RAM_SDATA(RAM_SDATA),
    .RAM_BYTE_SEL(RAM_BYTE_SEL),
    .RAM_LDATA(RAM_LDATA), .RAM_READY(RAM_READY),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_BE_N(SRAM_BE_N)
  );

  // Async SRAM model: reads drive the bus only when selected.
  assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N) ?
                     mem[SRAM_ADDR[7:0]] : 32'h0BADF00D;

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'hDEADBEEF;
      mem[8'h41] <= 32'h11223344;
    end else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) begin
      for (int b = 0; b < 4; b++)
        if (!SRAM_BE_N[b])
          mem[SRAM_ADDR[7:0]][8*b +: 8] <= SRAM_DQ_O[8*b +: 8];
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (!SRAM_WE_N && !SRAM_OE_N) viol++;
      if (SRAM_DQ_OE && !SRAM_OE_N) viol++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  sel;
    bit          chk_addr;
    logic [19:0] e_addr;
    logic [3:0]  e_be;
    int          e_lat;
    int          e_ce;
    int          e_oe;
    int          e_we;
    int          e_dq;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl [7];

  task automatic run_op(input vec_t v, input int idx);
    int lat = 0, ce = 0, oe = 0, we = 0, dq = 0;
    logic [19:0] a1 = '0;
    logic [3:0]  b1 = '0;
    logic [31:0] ld = '0;
    RAM_CEN      = 1'b1;
    RAM_WEN      = v.wen;
    RAM_LSADDR   = v.addr;
    RAM_SDATA    = v.sdata;
    RAM_BYTE_SEL = v.sel;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        a1 = SRAM_ADDR;
        b1 = SRAM_BE_N;
      end
      if (!SRAM_CE_N) ce++;
      if (!SRAM_OE_N) oe++;
      if (!SRAM_WE_N) we++;
      if (SRAM_DQ_OE) dq++;
      if (RAM_READY) begin
        lat = c;
        ld  = RAM_LDATA;
        RAM_CEN = 1'b0;
      end
    end
    RAM_CEN = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d_ce_cycles", idx), ce, v.e_ce);
    chk($sformatf("v%0d_oe_cycles", idx), oe, v.e_oe);
    chk($sformatf("v%0d_we_cycles", idx), we, v.e_we);
    chk($sformatf("v%0d_dqoe_cycles", idx), dq, v.e_dq);
    chk($sformatf("v%0d_be_n", idx), {28'h0, b1}, {28'h0, v.e_be});
    if (v.chk_addr)
      chk($sformatf("v%0d_sram_addr", idx), {12'h0, a1},
          {12'h0, v.e_addr});
    chk($sformatf("v%0d_ldata", idx), ld, v.e_ld);
    @(posedge CLK); #1;
    chk($sformatf("v%0d_ready_pulse", idx), {31'h0, RAM_READY}, 32'h0);
  endtask

  initial begin
    int r, rc;
    logic [31:0] ld2;

    tbl[0] = '{1'b0, 32'h00000100, 32'h0, 4'hF, 1'b1, 20'h00040,
               4'h0, 3, 2, 2, 0, 0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 32'h00000104, 32'h0000AB00, 4'h2, 1'b1, 20'h00041,
               4'hD, 5, 4, 0, 2, 4, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'h00000104, 32'h0, 4'hF, 1'b1, 20'h00041,
               4'h0, 3, 2, 2, 0, 0, 32'h1122AB44};
    tbl[3] = '{1'b1, 32'hFFC00100, 32'h55555555, 4'h0, 1'b0, 20'h0,
               4'hF, 1, 0, 0, 0, 0, 32'h1122AB44};
    tbl[4] = '{1'b0, 32'hFFC00100, 32'h0, 4'h1, 1'b1, 20'h00040,
               4'hE, 3, 2, 2, 0, 0, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 32'h00000108, 32'hA50000C3, 4'h9, 1'b1, 20'h00042,
               4'h6, 5, 4, 0, 2, 4, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 32'h00000108, 32'h0, 4'hF, 1'b1, 20'h00042,
               4'h0, 3, 2, 2, 0, 0, 32'hA50000C3};

    RST = 1'b0;
    preload = 1'b1;
    RAM_CEN = 1'b0;
    RAM_WEN = 1'b0;
    RAM_LSADDR = '0;
    RAM_SDATA = '0;
    RAM_BYTE_SEL = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'h0, RAM_READY}, 32'h0);
    chk("rst_ldata", RAM_LDATA, 32'h0);
    chk("rst_addr", {12'h0, SRAM_ADDR}, 32'h0);
    chk("rst_dq_o", SRAM_DQ_O, 32'h0);
    chk("rst_dq_oe", {31'h0, SRAM_DQ_OE}, 32'h0);
    chk("rst_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    chk("rst_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("rst_be_n", {28'h0, SRAM_BE_N}, 32'hF);
    preload = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 7; i++) run_op(tbl[i], i);
    chk("mem_word41", mem[8'h41], 32'h1122AB44);
    chk("mem_word42", mem[8'h42], 32'hA50000C3);

    // Back-to-back: store then load of the same word, CEN held high.
    r = 0; rc = 0; ld2 = '0;
    RAM_CEN = 1'b1;
    RAM_WEN = 1'b1;
    RAM_LSADDR = 32'h0000010C;
    RAM_SDATA = 32'h12345678;
    RAM_BYTE_SEL = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if (RAM_READY) begin
        r++;
        if (r == 1) RAM_WEN = 1'b0;
        if (r == 2) begin
          rc = c;
          ld2 = RAM_LDATA;
          RAM_CEN = 1'b0;
        end
      end
    end
    RAM_CEN = 1'b0;
    chk("b2b_ready_count", r, 2);
    chk("b2b_load_cycle", rc, 9);
    chk("b2b_load_data", ld2, 32'h12345678);

    // Reset while the write strobe is low.
    RAM_CEN = 1'b1;
    RAM_WEN = 1'b1;
    RAM_LSADDR = 32'h00000110;
    RAM_SDATA = 32'hFFFFFFFF;
    RAM_BYTE_SEL = 4'hF;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_rst_we_n", {31'h0, SRAM_WE_N}, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("mid_rst_dq_oe", {31'h0, SRAM_DQ_OE}, 32'h0);
    chk("mid_rst_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    chk("mid_rst_ready", {31'h0, RAM_READY}, 32'h0);
    chk("mid_rst_ldata", RAM_LDATA, 32'h0);
    RST = 1'b1;
    RAM_CEN = 1'b0;
    r = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (RAM_READY) r++;
    end
    chk("post_rst_no_ready", r, 0);
    run_op(tbl[0], 7);

    chk("pin_invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
